// File: rtl/ddr_line_buffer.sv
// One-line (4096-bit) staging buffer between the DDR controller FSM and the DDR port.
// Writes serialise the line into 128-bit beats and reads gather the beats back into the line.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a controller request
// LOAD_DONE | line captured from data_in, write_ok held until we_con low
// WR_BEAT   | issuing write beats to DDR
// WR_DONE   | flush complete, ddr_write_ok held until we_to_ddr low
// RD_BEAT   | issuing read commands and gathering returned beats
// RD_DONE   | fill complete, ddr_read_ok held until we_from_ddr low
module ddr_line_buffer #(
   parameter int BEAT_W     = 128,
   parameter int LINE_W     = 4096,
   parameter int DDR_ADDR_W = 28
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           addr_in,
   input  logic [LINE_W-1:0]     data_in,
   output logic [LINE_W-1:0]     data_out,
   input  logic                  we_con,
   input  logic                  re_con,
   input  logic                  we_to_ddr,
   input  logic                  we_from_ddr,
   output logic                  write_ok,
   output logic                  read_ok,
   output logic                  ddr_write_ok,
   output logic                  ddr_read_ok,
   output logic                  ddr_cmd_valid,
   input  logic                  ddr_cmd_ready,
   output logic                  ddr_cmd_we,
   output logic [DDR_ADDR_W-1:0] ddr_addr,
   output logic [BEAT_W-1:0]     ddr_wdata,
   input  logic [BEAT_W-1:0]     ddr_rdata,
   input  logic                  ddr_rdata_valid
);

   localparam int BEATS = LINE_W / BEAT_W;
   localparam int BW    = $clog2(BEATS);
   localparam int LA_W  = DDR_ADDR_W - BW;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   typedef enum logic [2:0] {
      IDLE, LOAD_DONE, WR_BEAT, WR_DONE, RD_BEAT, RD_DONE
   } stateT;

   stateT             state;
   logic [LINE_W-1:0] line;
   logic              lineValid;
   logic [LA_W-1:0]   lineAddr;
   logic [BW-1:0]     cmdBeat;
   logic [BW-1:0]     dataBeat;
   logic              cmdDone;
   logic              cmdAccept;
   logic              unusedOk;

   // cmdDone keeps the counter from ever wrapping past the last beat
   assign cmdAccept = ddr_cmd_valid & ddr_cmd_ready & ~cmdDone;

   assign data_out  = line;
   assign read_ok   = lineValid & ((state == IDLE) | (state == LOAD_DONE));
   assign ddr_addr  = {lineAddr, cmdBeat};
   assign ddr_wdata = line[cmdBeat*BEAT_W +: BEAT_W];
   assign unusedOk  = &{1'b0, re_con, addr_in[31:LA_W]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         line          <= '0;
         lineValid     <= 1'b0;
         lineAddr      <= '0;
         cmdBeat       <= '0;
         dataBeat      <= '0;
         cmdDone       <= 1'b0;
         write_ok      <= 1'b0;
         ddr_write_ok  <= 1'b0;
         ddr_read_ok   <= 1'b0;
         ddr_cmd_valid <= 1'b0;
         ddr_cmd_we    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (we_con) begin
                  line      <= data_in;
                  lineValid <= 1'b1;
                  write_ok  <= 1'b1;
                  state     <= LOAD_DONE;
               end else if (we_to_ddr) begin
                  lineAddr      <= addr_in[LA_W-1:0];
                  cmdBeat       <= '0;
                  cmdDone       <= 1'b0;
                  ddr_cmd_valid <= 1'b1;
                  ddr_cmd_we    <= 1'b1;
                  state         <= WR_BEAT;
               end else if (we_from_ddr) begin
                  lineAddr      <= addr_in[LA_W-1:0];
                  lineValid     <= 1'b0;
                  cmdBeat       <= '0;
                  dataBeat      <= '0;
                  cmdDone       <= 1'b0;
                  ddr_cmd_valid <= 1'b1;
                  ddr_cmd_we    <= 1'b0;
                  state         <= RD_BEAT;
               end
            end
            LOAD_DONE: begin
               if (!we_con) begin
                  write_ok <= 1'b0;
                  state    <= IDLE;
               end
            end
            WR_BEAT: begin
               if (cmdAccept) begin
                  if (cmdBeat == LAST_BEAT) begin
                     cmdDone       <= 1'b1;
                     ddr_cmd_valid <= 1'b0;
                     ddr_cmd_we    <= 1'b0;
                     ddr_write_ok  <= 1'b1;
                     state         <= WR_DONE;
                  end else begin
                     cmdBeat <= cmdBeat + BW'(1);
                  end
               end
            end
            WR_DONE: begin
               if (!we_to_ddr) begin
                  ddr_write_ok <= 1'b0;
                  state        <= IDLE;
               end
            end
            RD_BEAT: begin
               // command issue and data return run independently and may overlap
               if (cmdAccept) begin
                  if (cmdBeat == LAST_BEAT) begin
                     cmdDone       <= 1'b1;
                     ddr_cmd_valid <= 1'b0;
                  end else begin
                     cmdBeat <= cmdBeat + BW'(1);
                  end
               end
               if (ddr_rdata_valid) begin
                  line[dataBeat*BEAT_W +: BEAT_W] <= ddr_rdata;
                  if (dataBeat == LAST_BEAT) begin
                     lineValid     <= 1'b1;
                     ddr_read_ok   <= 1'b1;
                     ddr_cmd_valid <= 1'b0;
                     state         <= RD_DONE;
                  end else begin
                     dataBeat <= dataBeat + BW'(1);
                  end
               end
            end
            RD_DONE: begin
               if (!we_from_ddr) begin
                  ddr_read_ok <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
